// File: rtl/muldiv_sequencer.sv
// Iterative 32-bit multiply/divide engine with HI/LO ownership
// and the decode-stage stall it imposes while an operation runs.
module muldiv_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   input  logic        read_hi_lo,
   input  logic        write_hi,
   input  logic        write_lo,
   input  logic [31:0] write_data,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        stall
);

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t      state, state_nx;
   logic [5:0]  cnt;
   logic [1:0]  op_q;
   logic [31:0] m_q;
   logic [31:0] a_raw;
   logic [31:0] acc_hi;
   logic [31:0] acc_lo;
   logic        neg_q;
   logic        neg_r;
   logic        dz_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;

   logic        sgn;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [32:0] mul_sum;
   logic [32:0] div_sh;
   logic        div_ok;
   logic [31:0] div_diff;
   logic [63:0] prod;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   assign sgn   = ~op[0];
   assign a_mag = (sgn && operand_a[31]) ? -operand_a : operand_a;
   assign b_mag = (sgn && operand_b[31]) ? -operand_b : operand_b;

   // m_q holds the multiplicand for MUL and the divisor for DIV
   assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_q} : 33'd0);
   assign div_sh   = {acc_hi, acc_lo[31]};
   assign div_ok   = div_sh >= {1'b0, m_q};
   assign div_diff = div_sh[31:0] - m_q;

   always_comb begin
      prod   = {acc_hi, acc_lo};
      res_hi = acc_hi;
      res_lo = acc_lo;
      if (!op_q[1]) begin
         if (!op_q[0] && neg_q)
            prod = -prod;
         res_hi = prod[63:32];
         res_lo = prod[31:0];
      end else if (dz_q) begin
         res_hi = a_raw;
         res_lo = 32'hFFFF_FFFF;
      end else begin
         if (!op_q[0] && neg_q)
            res_lo = -acc_lo;
         if (!op_q[0] && neg_r)
            res_hi = -acc_hi;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (cnt == 6'd31) state_nx = FINISH;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         op_q   <= '0;
         m_q    <= '0;
         a_raw  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         dz_q   <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt    <= '0;
                  op_q   <= op;
                  a_raw  <= operand_a;
                  acc_hi <= '0;
                  m_q    <= op[1] ? b_mag : a_mag;
                  acc_lo <= op[1] ? a_mag : b_mag;
                  neg_q  <= operand_a[31] ^ operand_b[31];
                  neg_r  <= operand_a[31];
                  dz_q   <= op[1] && (operand_b == '0);
               end else begin
                  if (write_hi) hi_q <= write_data;
                  if (write_lo) lo_q <= write_data;
               end
            end
            RUN: begin
               cnt <= cnt + 6'd1;
               if (!op_q[1]) begin
                  acc_hi <= mul_sum[32:1];
                  acc_lo <= {mul_sum[0], acc_lo[31:1]};
               end else begin
                  acc_hi <= div_ok ? div_diff : div_sh[31:0];
                  acc_lo <= {acc_lo[30:0], div_ok};
               end
            end
            FINISH: begin
               hi_q <= res_hi;
               lo_q <= res_lo;
            end
            default: ;
         endcase
      end
   end

   assign hi    = hi_q;
   assign lo    = lo_q;
   assign busy  = (state != IDLE);
   assign done  = (state == FINISH);
   assign stall = busy & (start | read_hi_lo | write_hi | write_lo);

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Iterative multiply/divide unit and its stall sequencer for the decode stage: accepts MULT/MULTU/DIV/DIVU from decode, runs a 32-iteration shift-add or restoring-divide engine, and owns the architectural HI/LO registers. It raises a combinational stall to the hazard logic (PC and IF/ID write disable, ID/EX bubble) whenever decode needs HI/LO or the engine while an operation is in flight.

## Interface
- No parameters; data width fixed at 32.
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high; one clock, one reset.
- Start  in  1  decode holds a mul/div instruction (already qualified: low when ID is flushed).
- Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
- OperandA  in  32  rs value after branch-style forwarding (multiplicand / dividend).
- OperandB  in  32  rt value after forwarding (multiplier / divisor).
- ReadHiLo  in  1  decode holds MFHI or MFLO.
- WriteHi, WriteLo  in  1 each  decode holds MTHI / MTLO.
- WriteData  in  32  rs value for MTHI/MTLO.
- Hi, Lo  out  32 each  architectural HI/LO register contents.
- Busy  out  1  engine occupied (RUN or FINISH).
- Done  out  1  one-cycle pulse in the FINISH cycle.
- Stall  out  1  combinational: Busy & (Start | ReadHiLo | WriteHi | WriteLo).

## Operation
- States: IDLE, RUN, FINISH. 6-bit iteration counter.
- IDLE: Start=1 → latch Op, magnitudes |A|,|B| (signed ops) or raw values (unsigned ops), result signs; counter=0; → RUN. Start has priority over WriteHi/WriteLo in the same cycle (cannot legally co-occur; priority defined for determinism).
- IDLE, no Start: WriteHi loads Hi from WriteData; WriteLo loads Lo; both may assert together.
- RUN: one iteration per cycle; counter increments; after iteration 32 (counter=31 at edge) → FINISH.
- Multiply: unsigned shift-add on magnitudes into 64-bit accumulator. Signed: negate 64-bit product if sign(A)^sign(B).
- Divide: restoring, 32 quotient bits MSB-first, 33-bit partial remainder. Signed: quotient negated if sign(A)^sign(B); remainder takes sign of A. DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0.
- Divide by zero (DIV or DIVU): full latency, forced result Hi=OperandA as latched, Lo=0xFFFFFFFF.
- FINISH: sign fixup combinational; Hi ← high/remainder, Lo ← low/quotient at end of cycle; Done=1; → IDLE.
- Engine and HI/LO are never written by MTHI/MTLO while Busy; those instructions stall instead.
- Stalled Start in decode is re-presented by the frozen IF/ID; accepted in the first IDLE cycle (Stall low then).

## Timing
- Reset: state IDLE, counter 0, Hi=0, Lo=0, Busy=0, Done=0, Stall=0 (given inputs low). Reset mid-RUN or FINISH aborts with no HI/LO update.
- Start accepted in cycle 0; RUN cycles 1–32; FINISH cycle 33 (Done=1); Busy=1 cycles 1–33; new Hi/Lo visible from cycle 34.
- Back-to-back: second mul/div in decode stalls cycles 1–33, accepted cycle 34, Done in cycle 67.
- MFHI/MFLO in decode during cycles 1–33 stalls; released cycle 34 reading new value. No bypass of FINISH result.
- Stall is purely combinational from current state and inputs; no registered delay.
- Operands sampled only at acceptance; later OperandA/B changes ignored.

## Test plan
- Reset, then MULTU 0xFFFFFFFF × 0xFFFFFFFF → Done in cycle 33; Hi=0xFFFFFFFE, Lo=0x00000001 from cycle 34; Busy high exactly cycles 1–33.
- MULT 0xFFFFFFFD (−3) × 5 → Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; DIV −7 / 2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU 100 / 7 → Lo=14, Hi=2.
- DIV 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0; DIVU 0x1234 / 0 → Hi=0x1234, Lo=0xFFFFFFFF after full latency.
- MULT issued, MFLO held in decode from cycle 1 → Stall=1 cycles 1–33, 0 in cycle 34 with Lo already updated; second MULT held from cycle 1 → accepted cycle 34, Done cycle 67.
- Idle MTHI 0xA5A5A5A5 + MTLO 0x5A5A5A5A same cycle → both loaded next edge, Stall=0; MTHI while Busy → Stall=1, Hi unchanged until accepted after completion.
- Reset asserted in cycle 20 of a DIV → next cycle IDLE, Busy=0, Hi=Lo=0, no Done pulse.
